// File: rtl/mux_4_1.sv
// Registered 4-to-1 multiplexer with one cycle of latency and an asynchronous active-low reset.
// Defining MUX_4_1_PARITY_EN adds y_par, a registered XOR of the bits loaded into y.
module mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
`ifdef MUX_4_1_PARITY_EN
    output logic             y_par,
`endif
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_selData;
    logic [WIDTH-1:0] r_y;

    // A select that is not a clean 2-state value steers zero into the register.
    always_comb begin
        w_selData = '0;
        case (sel)
            2'b00:   w_selData = I0;
            2'b01:   w_selData = I1;
            2'b10:   w_selData = I2;
            2'b11:   w_selData = I3;
            default: w_selData = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_selData;
        end
    end

    assign y = r_y;

`ifdef MUX_4_1_PARITY_EN
    logic r_yPar;

    // Parity comes from the same data that loads r_y, so it stays aligned with y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_yPar <= 1'b0;
        end else begin
            r_yPar <= ^w_selData;
        end
    end

    assign y_par = r_yPar;
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: a scoreboard queue holds expected y values.
// Parity checks are compiled in when MUX_4_1_PARITY_EN is defined.
module tb_mux_4_1;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       sel = 2'b11;
    logic [WIDTH-1:0] I0 = 4'd1;
    logic [WIDTH-1:0] I1 = 4'd2;
    logic [WIDTH-1:0] I2 = 4'd3;
    logic [WIDTH-1:0] I3 = 4'd4;
    logic [WIDTH-1:0] y;
`ifdef MUX_4_1_PARITY_EN
    logic             y_par;
`endif

    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] lastY = '0;
    int checkCount = 0;
    int passCount  = 0;

    mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
`ifdef MUX_4_1_PARITY_EN
        .y_par (y_par),
`endif
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: what y should capture at the next rising edge.
    function automatic logic [WIDTH-1:0] modelY();
        if (!rst) return '0;
        case (sel)
            2'b00:   return I0;
            2'b01:   return I1;
            2'b10:   return I2;
            2'b11:   return I3;
            default: return '0;
        endcase
    endfunction

    task automatic checkParity(input string tag, input logic [WIDTH-1:0] expY);
`ifdef MUX_4_1_PARITY_EN
        checkOutput({tag, "_par"}, {31'd0, y_par}, {31'd0, ^expY});
`else
        if (tag.len() < 0) $display("[TB] %s %0h", tag, expY);
`endif
    endtask

    task automatic collect(input string tag);
        logic [WIDTH-1:0] expY;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            expY = expQ.pop_front();
            checkOutput(tag, {28'd0, y}, {28'd0, expY});
            checkParity(tag, expY);
            lastY = expY;
        end
    endtask

    // Drive mid-cycle, confirm y has not moved combinationally, then score after the edge.
    task automatic applyStimulus(input string tag, input logic r, input logic [1:0] s,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst = r;
        sel = s;
        I0  = a;
        I1  = b;
        I2  = c;
        I3  = d;
        #1;
        checkOutput({tag, "_nocomb"}, {28'd0, y}, {28'd0, lastY});
        expQ.push_back(modelY());
        @(posedge clk);
        #1;
        collect(tag);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_async_start", {28'd0, y}, 32'd0);
        checkParity("reset_async_start", '0);

        applyStimulus("reset_hold0", 1'b0, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("reset_hold1", 1'b0, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);

        applyStimulus("sweep_sel00", 1'b1, 2'b00, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("sweep_sel01", 1'b1, 2'b01, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("sweep_sel10", 1'b1, 2'b10, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("sweep_sel11", 1'b1, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("hold_sel11",  1'b1, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);

        // Assert reset between edges while y=4; y must clear without a clock edge.
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_async_mid", {28'd0, y}, 32'd0);
        checkParity("reset_async_mid", '0);
        lastY = '0;
        applyStimulus("reset_mid_hold", 1'b0, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);

        applyStimulus("latency_sel00", 1'b1, 2'b00, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("latency_sel10", 1'b1, 2'b10, 4'd1, 4'd2, 4'd3, 4'd4);

        applyStimulus("track_i1_0", 1'b1, 2'b01, 4'd1, 4'h0, 4'd3, 4'd4);
        applyStimulus("track_i1_f", 1'b1, 2'b01, 4'd1, 4'hF, 4'd3, 4'd4);
        applyStimulus("track_i1_a", 1'b1, 2'b01, 4'd1, 4'hA, 4'd3, 4'd4);
        applyStimulus("unsel_i0",   1'b1, 2'b01, 4'h9, 4'hA, 4'd3, 4'd4);
        applyStimulus("unsel_i2i3", 1'b1, 2'b01, 4'h9, 4'hA, 4'h6, 4'hC);

        for (int i = 0; i < 6; i++) begin
            applyStimulus("random", 1'b1, 2'($urandom_range(0, 3)),
                          4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        applyStimulus("illegal_sel", 1'b1, 2'bxx, 4'd1, 4'd2, 4'd3, 4'd4);
        applyStimulus("after_illegal_sel11", 1'b1, 2'b11, 4'd1, 4'd2, 4'd3, 4'd4);

        applyStimulus("parity_0111", 1'b1, 2'b10, 4'd1, 4'd2, 4'b0111, 4'd4);
        applyStimulus("parity_0011", 1'b1, 2'b10, 4'd1, 4'd2, 4'b0011, 4'd4);

        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
